// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS execute-stage multiply/divide unit owning HI/LO
//
// Purpose: executes mult, multu, div, divu, mthi and mtlo. Multiply and divide
// results are computed in the accept cycle and parked in shadow registers.
// They commit to HI/LO after a fixed busy window, which hides the latency from
// the hazard unit.
//
// Ports:
//   clk_i       rising-edge clock
//   reset_i     asynchronous active-low reset
//   op_valid_i  md-class instruction present in E
//   op_i        1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo, others no-op
//   a_i, b_i    forwarded rs / rt operands
//   int_req_i   E instruction is being flushed this cycle
//   busy_o      multiply/divide in flight
//   hi_o, lo_o  architectural HI / LO
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        op_valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        int_req_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
   logic          wr_q, wr_d;   // shadow holds a result worth committing

   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg, div_zero, accept;
   logic [31:0] a_mag, b_mag, uq, ur, sq_mag, sr_mag, sq, sr;

   // Low 64 bits of a 64x64 product of sign-extended operands equal the
   // signed 32x32 product.
   assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to
   // 0x80000000 instead of relying on signed-overflow behaviour.
   assign a_neg    = a_i[31];
   assign b_neg    = b_i[31];
   assign a_mag    = a_neg ? (~a_i + 32'd1) : a_i;
   assign b_mag    = b_neg ? (~b_i + 32'd1) : b_i;
   assign div_zero = (b_i == 32'd0);
   assign uq       = div_zero ? 32'd0 : (a_i / b_i);
   assign ur       = div_zero ? 32'd0 : (a_i % b_i);
   assign sq_mag   = div_zero ? 32'd0 : (a_mag / b_mag);
   assign sr_mag   = div_zero ? 32'd0 : (a_mag % b_mag);
   assign sq       = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
   assign sr       = a_neg ? (~sr_mag + 32'd1) : sr_mag;

   assign busy_o = (cnt_q != '0);
   assign accept = op_valid_i && !int_req_i && !busy_o;

   always_comb begin
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sh_hi_d = sh_hi_q;
      sh_lo_d = sh_lo_q;
      wr_d    = wr_q;
      if (busy_o) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1) && wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
         end
      end else if (accept) begin
         case (op_i)
            OP_MULT: begin
               sh_hi_d = prod_s[63:32];
               sh_lo_d = prod_s[31:0];
               wr_d    = 1'b1;
               cnt_d   = CW'(MULT_CYCLES);
            end
            OP_MULTU: begin
               sh_hi_d = prod_u[63:32];
               sh_lo_d = prod_u[31:0];
               wr_d    = 1'b1;
               cnt_d   = CW'(MULT_CYCLES);
            end
            OP_DIV: begin
               sh_hi_d = sr;
               sh_lo_d = sq;
               wr_d    = !div_zero;   // divide by zero leaves HI/LO untouched
               cnt_d   = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
               sh_hi_d = ur;
               sh_lo_d = uq;
               wr_d    = !div_zero;
               cnt_d   = CW'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sh_hi_q <= '0;
         sh_lo_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sh_hi_q <= sh_hi_d;
         sh_lo_q <= sh_lo_d;
         wr_q    <= wr_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the execute stage of the five-stage MIPS pipeline, directly upstream of the E/M pipeline register.
- Owns the HI/LO architectural registers and executes mult, multu, div, divu, mthi and mtlo with a fixed multi-cycle latency.
- Exposes busy so the hazard unit can stall md instructions and mfhi/mflo in D.
- Its hi/lo outputs feed the E/M register, which selects them as AO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, number of busy cycles for div/divu (must be >=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op_valid  input  1  an md-class instruction is in E this cycle
- op  input  3  1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; others = no-op
- a  input  32  forwarded rs value of the E instruction
- b  input  32  forwarded rt value of the E instruction
- int_req  input  1  interrupt/exception taken this cycle; the E instruction is being flushed
- busy  output  1  a mult/div is in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, shadow result registers=0. Reset asserted mid-operation aborts it, and no commit occurs after release.
- Accept condition: op_valid=1, int_req=0, busy=0. With int_req=1, nothing is accepted in that cycle, including mthi/mtlo.
- Illegal overlap: op_valid while busy=1 is ignored. The hazard unit prevents it; the bench checks the ignore.
- mult/multu/div/divu accepted at edge T:
  - The 64-bit result is computed from a/b at T and latched into shadow hi/lo.
  - counter loads MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0), registered. It is high exactly N cycles starting the cycle after T.
- Each edge with counter != 0 decrements the counter. At the edge where counter==1, shadow values commit to hi/lo.
- New hi/lo are therefore visible in the first cycle busy=0, which is the cycle the stalled mfhi/mflo enters E.
- mthi/mtlo accepted at edge T: hi (or lo) = a at T. No busy, and the other register is unchanged.
- int_req while busy=1: the in-flight operation continues and commits. That instruction has already left E and is architecturally committed.
- Arithmetic:
  - mult: signed 32x32 -> 64, {hi,lo}.
  - multu: unsigned 32x32 -> 64.
  - div: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - 0x80000000 / 0xFFFFFFFF (div): lo=0x80000000, hi=0.
  - Divide by zero (div or divu): busy runs the full DIV_CYCLES, and hi/lo are left unchanged at commit.
- Unknown op values with op_valid=1: no state change, busy stays 0.
- hi/lo change only on the commit edge, mthi/mtlo, or reset.

Test Plan:
- mult: a=0xFFFFFFFF, b=0x00000002 accepted at edge 0 -> busy=1 for cycles 1..5; cycle 6 busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFE. hi/lo hold old values through cycle 5.
- multu and divu:
  - multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
  - divu a=7, b=2 -> 10 busy cycles, then lo=3, hi=1.
- div edge cases:
  - div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - div by 0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22.
- Cancellation:
  - op_valid with mult and int_req=1 in the same cycle -> busy stays 0, hi/lo unchanged.
  - mthi a=0x1234 with int_req=1 -> hi unchanged.
  - int_req pulsed in cycle 3 of an accepted mult -> the result still commits in cycle 6.
- Overlap and move ops:
  - mult accepted, then a second div with op_valid in cycle 2 -> ignored; busy falls after cycle 5 with the mult result.
  - mtlo a=0xCAFE (busy=0) -> lo=0xCAFE next cycle, hi unchanged, busy=0.
- Reset: reset=0 asserted asynchronously mid-clock during cycle 3 of a div -> busy, hi and lo go to 0 immediately. After release, no commit occurs and busy stays 0.
